// File: rtl/rvx_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rvx_dmem_pkg
// Description : Shared types, encodings and helpers for the RVX data-memory
//               controller.
// Revision    : 1.0
// ============================================================================
package rvx_dmem_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SPLIT = 2'd2
  } state_e;

  // Number of bytes touched by an access of the given size.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Lane mask over two consecutive words: bits [3:0] are the lanes of the
  // addressed word, bits [7:4] the lanes of the following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'b0000_0001;
      SZ_H:    base = 8'b0000_0011;
      default: base = 8'b0000_1111;
    endcase
    return base << offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bank
// Description : One byte-wide synchronous-read RAM lane with write enable.
// Revision    : 1.0
// ============================================================================
module dmem_bank #(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [7:0]                     wdata_i,
  output logic [7:0]                     rdata_o
);

  logic [7:0] mem_q [DEPTH_WORDS];
  logic [7:0] rdata_q;

  // Write on enable; always read the addressed entry with one cycle latency.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ctrl
// Description : Banked data-memory controller: byte/half/word loads and
//               stores, word-crossing split, range check, post-reset clear.
// Revision    : 1.0
// ============================================================================
module dmem_ctrl
  import rvx_dmem_pkg::*;
#(
  parameter int DEPTH_BYTES  = 8192,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic             reqWe,
  input  logic [1:0]       reqSize,
  input  logic             reqUnsigned,
  input  logic [BUS_W-1:0] reqAddr,
  input  logic [BUS_W-1:0] reqWData,
  output logic             rspValid,
  output logic [BUS_W-1:0] rspRData,
  output logic             rspErr
);

  localparam int     DEPTH_WORDS = DEPTH_BYTES / 4;
  localparam int     AW          = $clog2(DEPTH_BYTES);
  localparam int     WAW         = AW - 2;
  localparam state_e RST_STATE   = CLEAR_ON_RST ? CLEAR : IDLE;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [1:0]     req_off;
  logic [WAW-1:0] req_idx;
  logic [2:0]     req_bytes;
  logic [BUS_W:0] req_last;
  logic           req_err;
  logic [7:0]     req_mask;
  logic           req_cross;
  logic           accept;
  logic [63:0]    req_wide;

  assign req_off   = reqAddr[1:0];
  assign req_idx   = reqAddr[AW-1:2];
  assign req_bytes = size_bytes(reqSize);
  // One extra bit so the last-byte address never wraps.
  assign req_last  = {1'b0, reqAddr} + (BUS_W+1)'(req_bytes) - (BUS_W+1)'(1);
  assign req_err   = (reqSize == SZ_RSV) || (req_last >= (BUS_W+1)'(DEPTH_BYTES));
  assign req_mask  = lane_mask(reqSize, req_off);
  assign req_cross = (|req_mask[7:4]) && !req_err;
  assign accept    = reqValid && reqReady;
  // Store data moved onto its byte lanes across two words.
  assign req_wide  = {32'b0, reqWData} << {req_off, 3'b000};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [WAW-1:0] clr_idx_q;

  logic [1:0]     op_off_q;
  logic [1:0]     op_size_q;
  logic           op_uns_q;
  logic           op_we_q;
  logic           op_split_q;
  logic [WAW-1:0] split_idx_q;
  logic [3:0]     split_mask_q;
  logic [31:0]    split_wdata_q;
  logic [31:0]    lo_q;
  logic           rsp_valid_q;
  logic           rsp_err_q;

  logic [WAW-1:0] bank_addr;
  logic [3:0]     bank_we;
  logic [31:0]    bank_wdata;
  logic [31:0]    rd_word;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: sweep until the last word, split on word-crossing accesses.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR: if (clr_idx_q == WAW'(DEPTH_WORDS - 1)) state_d = IDLE;
      IDLE:  if (accept && req_cross) state_d = SPLIT;
      SPLIT: state_d = IDLE;
      default: state_d = RST_STATE;
    endcase
  end

  // Outputs: handshake and bank port steering per state.
  always_comb begin
    reqReady   = (state_q == IDLE);
    bank_addr  = req_idx;
    bank_we    = 4'b0000;
    bank_wdata = req_wide[31:0];
    case (state_q)
      CLEAR: begin
        bank_addr  = clr_idx_q;
        bank_we    = 4'b1111;
        bank_wdata = 32'b0;
      end
      IDLE: begin
        if (accept && !req_err) begin
          bank_we = req_mask[3:0] & {4{reqWe}};
        end
      end
      SPLIT: begin
        bank_addr  = split_idx_q;
        bank_we    = split_mask_q & {4{op_we_q}};
        bank_wdata = split_wdata_q;
      end
      default: begin
        bank_we = 4'b0000;
      end
    endcase
  end

  // Clear sweep index; wraps back to 0 as the sweep finishes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_idx_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_idx_q <= clr_idx_q + WAW'(1);
    end
  end

  // Latch the accepted operation and the second-word part of a split access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_off_q      <= '0;
      op_size_q     <= '0;
      op_uns_q      <= 1'b0;
      op_we_q       <= 1'b0;
      op_split_q    <= 1'b0;
      split_idx_q   <= '0;
      split_mask_q  <= '0;
      split_wdata_q <= '0;
    end else if (accept) begin
      op_off_q      <= req_off;
      op_size_q     <= reqSize;
      op_uns_q      <= reqUnsigned;
      op_we_q       <= reqWe;
      op_split_q    <= req_cross;
      split_idx_q   <= req_idx + WAW'(1);
      split_mask_q  <= req_mask[7:4];
      split_wdata_q <= req_wide[63:32];
    end
  end

  // Response flags, plus capture of the first word during a split.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      lo_q        <= '0;
    end else begin
      rsp_valid_q <= (accept && !req_cross) || (state_q == SPLIT);
      rsp_err_q   <= accept && req_err;
      if (state_q == SPLIT) begin
        lo_q <= rd_word;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Banks
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < 4; k++) begin : g_bank
    dmem_bank #(
      .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
      .clk    (clk),
      .we_i   (bank_we[k]),
      .addr_i (bank_addr),
      .wdata_i(bank_wdata[8*k +: 8]),
      .rdata_o(rd_word[8*k +: 8])
    );
  end

  // --------------------------------------------------------------------------
  // Load reassembly and extension
  // --------------------------------------------------------------------------
  logic [63:0] raw64;
  logic [31:0] aligned;
  logic [31:0] ext;

  // Little-endian reassembly, then sign/zero extension; zero unless a load.
  always_comb begin
    raw64   = op_split_q ? {rd_word, lo_q} : {32'b0, rd_word};
    aligned = 32'(raw64 >> {op_off_q, 3'b000});
    case (op_size_q)
      SZ_B:    ext = op_uns_q ? {24'b0, aligned[7:0]}
                              : {{24{aligned[7]}}, aligned[7:0]};
      SZ_H:    ext = op_uns_q ? {16'b0, aligned[15:0]}
                              : {{16{aligned[15]}}, aligned[15:0]};
      default: ext = aligned;
    endcase
    rspRData = (rsp_valid_q && !rsp_err_q && !op_we_q) ? ext : 32'b0;
  end

  assign rspValid = rsp_valid_q;
  assign rspErr   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_ctrl
// Description : Scoreboard bench for dmem_ctrl with a 64-byte memory.
// Revision    : 1.0
// ============================================================================
module tb_dmem_ctrl;
  import rvx_dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqUnsigned = 1'b0;
  logic [31:0] reqAddr = 32'h0;
  logic [31:0] reqWData = 32'h0;
  logic        rspValid;
  logic [31:0] rspRData;
  logic        rspErr;

  dmem_ctrl #(
    .DEPTH_BYTES (64),
    .CLEAR_ON_RST(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqWe      (reqWe),
    .reqSize    (reqSize),
    .reqUnsigned(reqUnsigned),
    .reqAddr    (reqAddr),
    .reqWData   (reqWData),
    .rspValid   (rspValid),
    .rspRData   (rspRData),
    .rspErr     (rspErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t sbq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare whenever a response appears; flag late ones.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rspValid) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rspValid=1 data %h expected no response", rspRData);
      end else begin
        e = sbq.pop_front();
        check({e.name, "_data"}, rspRData, e.data);
        check({e.name, "_err"}, {31'b0, rspErr}, {31'b0, e.err});
        check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL %s_missing: got no response by cycle %0d expected one at %0d", e.name, cyc, e.due);
    end
  end

  // Drive a request (called at a negedge), wait for acceptance, queue result.
  task automatic issue(input string nm, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input logic exp_e, input int lat);
    int n;
    n = 0;
    reqValid    = 1'b1;
    reqWe       = we;
    reqSize     = sz;
    reqUnsigned = uns;
    reqAddr     = addr;
    reqWData    = wd;
    while (!reqReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got reqReady=0 for 100 cycles expected 1", nm);
      reqValid = 1'b0;
      return;
    end
    sbq.push_back('{exp_d, exp_e, cyc + lat, nm});
    @(negedge clk);
    if (lat == 2) check({nm, "_ready_low"}, {31'b0, reqReady}, 32'h0);
  endtask

  // After reset release: reqReady low for 16 cycles, then high.
  task automatic clear_check(input string nm);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check($sformatf("%s_ready_k%0d", nm, k), {31'b0, reqReady}, (k >= 16) ? 32'h1 : 32'h0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_rspValid", {31'b0, rspValid}, 32'h0);
    check("rst_rspRData", rspRData, 32'h0);
    check("rst_rspErr", {31'b0, rspErr}, 32'h0);
    check("rst_reqReady", {31'b0, reqReady}, 32'h0);

    rst = 1'b1;
    clear_check("clr1");

    issue("lw_3C_clear", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0, 1);

    // Extension
    issue("sw_10",   1'b1, SZ_W, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    issue("lb_13",   1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, 1);
    issue("lbu_13",  1'b0, SZ_B, 1'b1, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, 1);
    issue("lh_12",   1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0, 1);
    issue("lhu_10",  1'b0, SZ_H, 1'b1, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0, 1);

    // Split
    issue("sw_0E",   1'b1, SZ_W, 1'b0, 32'h0E, 32'h1122_3344, 32'h0, 1'b0, 2);
    issue("lw_0E",   1'b0, SZ_W, 1'b0, 32'h0E, 32'h0, 32'h1122_3344, 1'b0, 2);
    issue("lw_0C",   1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, 32'h3344_0000, 1'b0, 1);
    issue("lw_10",   1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEAD_1122, 1'b0, 1);
    issue("lh_0F",   1'b0, SZ_H, 1'b0, 32'h0F, 32'h0, 32'h0000_2233, 1'b0, 2);

    // Errors and range boundary
    issue("lw_3E_err",  1'b0, SZ_W,   1'b0, 32'h3E, 32'h0, 32'h0, 1'b1, 1);
    issue("sh_3F_err",  1'b1, SZ_H,   1'b0, 32'h3F, 32'h0000_FFFF, 32'h0, 1'b1, 1);
    issue("rsv_0C_err", 1'b1, SZ_RSV, 1'b0, 32'h0C, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue("sw_3E_err",  1'b1, SZ_W,   1'b0, 32'h3E, 32'hFFFF_FFFF, 32'h0, 1'b1, 1);
    issue("lw_40_err",  1'b0, SZ_W,   1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1);
    issue("lw_3C_keep", 1'b0, SZ_W,   1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0, 1);
    issue("lw_0C_keep", 1'b0, SZ_W,   1'b0, 32'h0C, 32'h0, 32'h3344_0000, 1'b0, 1);
    issue("sb_3F",      1'b1, SZ_B,   1'b0, 32'h3F, 32'h0000_005A, 32'h0, 1'b0, 1);
    issue("lb_3F",      1'b0, SZ_B,   1'b0, 32'h3F, 32'h0, 32'h0000_005A, 1'b0, 1);

    // Throughput: consecutive aligned loads, due cycles are consecutive
    issue("tp0_0C", 1'b0, SZ_W, 1'b0, 32'h0C, 32'h0, 32'h3344_0000, 1'b0, 1);
    issue("tp1_10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEAD_1122, 1'b0, 1);
    issue("tp2_3C", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'h5A00_0000, 1'b0, 1);
    issue("tp3_14", 1'b0, SZ_W, 1'b0, 32'h14, 32'h0, 32'h0000_0000, 1'b0, 1);
    reqValid = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during the SPLIT cycle of a load: no response, sweep restarts
    reqValid    = 1'b1;
    reqWe       = 1'b0;
    reqSize     = SZ_W;
    reqUnsigned = 1'b0;
    reqAddr     = 32'h0E;
    @(negedge clk);
    check("abort_in_split", {31'b0, reqReady}, 32'h0);
    reqValid = 1'b0;
    rst      = 1'b0;
    #1;
    check("abort_rspValid", {31'b0, rspValid}, 32'h0);
    check("abort_rspRData", rspRData, 32'h0);
    check("abort_rspErr", {31'b0, rspErr}, 32'h0);
    check("abort_reqReady", {31'b0, reqReady}, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    clear_check("clr2");
    issue("lw_10_clr2", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h0000_0000, 1'b0, 1);
    issue("lw_3C_clr2", 1'b0, SZ_W, 1'b0, 32'h3C, 32'h0, 32'h0000_0000, 1'b0, 1);
    reqValid = 1'b0;
    repeat (4) @(negedge clk);

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      tests++;
      fails++;
      $display("FAIL %s_leftover: got no response expected one at cycle %0d", e.name, e.due);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller for the RVX load/store path. It replaces the flat byte-array data memory with four synchronous-read byte banks behind a valid/ready request port and a registered response port. It adds byte, half and word loads with sign or zero extension, splits word-crossing accesses into two cycles, flags out-of-range accesses, and optionally zero-fills the memory after reset with a sweep state machine. It sits between the MEM stage and on-chip SRAM.

## Interface
- `DEPTH_BYTES`, 8192: memory size in bytes. Must be a power of two and at least 16. `DEPTH_WORDS = DEPTH_BYTES/4`.
- `CLEAR_ON_RST`, 1: when 1, zero-fill every word after reset before accepting requests.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `reqValid`  in  1  request present.
- `reqReady`  out  1  controller accepts a request this cycle.
- `reqWe`  in  1  1 = store, 0 = load.
- `reqSize`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
- `reqUnsigned`  in  1  zero-extend loads; ignored for word loads and stores.
- `reqAddr`  in  `BUS_W`  byte address.
- `reqWData`  in  `BUS_W`  store data, right-aligned.
- `rspValid`  out  1  single-cycle response pulse.
- `rspRData`  out  `BUS_W`  extended load data. It is 0 for stores and errors.
- `rspErr`  out  1  out-of-range or reserved size. Valid with `rspValid`.

## Operation
- Storage: 4 byte banks of `DEPTH_WORDS`×8. Lane k holds byte address `4*idx+k`. Writes are synchronous and per-lane; reads are synchronous with 1-cycle latency.
- Handshake: a request is accepted when `reqValid && reqReady`. The requester holds request fields stable while `reqReady` is low. There is no response backpressure.
- Error check (at accept): if `addr + bytes - 1 >= DEPTH_BYTES` or `reqSize == 11`, no bank is accessed. The response has `rspErr=1` and `rspRData=0`. Addresses never wrap.
- Aligned or within-word access (for example, a half at offset 1): single bank access.
- Word-crossing access (a half at offset 3, or a word at offset 1–3): split access.
  - First cycle: word `idx`, low lanes.
  - Next cycle: word `idx+1`, remaining lanes.
  - Load bytes are reassembled in little-endian order.
- Load extension: the byte/half result is sign-extended from bit 7/15 unless `reqUnsigned` is set.
- States:
  - `CLEAR`: write 0 to word `clrIdx`, then increment. When `clrIdx == DEPTH_WORDS-1`, go to `IDLE`.
  - `IDLE`: accept requests. A crossing access goes to `SPLIT`; all others stay in `IDLE`.
  - `SPLIT`: second word access, then go to `IDLE`.
- `reqReady = (state == IDLE)`.
- Reset exit goes to `CLEAR` if `CLEAR_ON_RST`, else to `IDLE`.

## Timing
- Reset values: `rspValid=0`, `rspRData=0`, `rspErr=0`, `clrIdx=0`, state `CLEAR` (or `IDLE`).
- `reqReady` during and after reset is 0 if `CLEAR_ON_RST`, else 1.
- Clear duration: exactly `DEPTH_WORDS` cycles after `rst` rises, then `reqReady=1`.
- Single access accepted at cycle N gives a response at N+1. Aligned throughput is 1 request per cycle; a new accept may coincide with `rspValid`.
- Split access accepted at N: `reqReady=0` at N+1, response at N+2.
- Error response: always N+1, never `SPLIT`.
- Reset asserted mid-`SPLIT`: the operation is aborted and no response is produced. A committed first-half store write remains in memory. Reset asserted mid-`CLEAR` restarts the sweep from 0.
- Response outputs are valid only in the `rspValid` cycle and return to 0 afterwards.

## Structure
- Package `rvx_dmem_pkg` holds:
  - the `BUS_W` reference;
  - size encodings `SZ_B`, `SZ_H`, `SZ_W`;
  - the state enum `{CLEAR, IDLE, SPLIT}`;
  - a lane-mask function (size and offset to a 4-bit mask per word).
- Sub-module `dmem_bank`: one sync-read, byte-wide, `DEPTH_WORDS` RAM with write enable. Instantiated 4×.
- Top level holds the FSM, error check, split and reassembly, and extension.

## Test plan
- Clear: `DEPTH_BYTES=64`, release reset. `reqReady` stays 0 for 16 cycles, then goes to 1. `lw 0x3C` returns 0x00000000.
- Extension: `sw 0xDEADBEEF @0x10` gives an ack with `rspRData=0`. Then:
  - `lb 0x13` returns 0xFFFFFFDE;
  - `lbu 0x13` returns 0x000000DE;
  - `lh 0x12` returns 0xFFFFDEAD;
  - `lhu 0x10` returns 0x0000BEEF.
- Split: after the extension scenario, `sw 0x11223344 @0x0E` gives `reqReady=0` for one cycle and a response at N+2. Then:
  - `lw 0x0E` returns 0x11223344 (at N+2);
  - `lw 0x0C` returns 0x33440000;
  - `lw 0x10` returns 0xDEAD1122.
- Errors (`DEPTH_BYTES=64`):
  - `lw 0x3E` gives `rspErr=1`, data 0, at N+1;
  - `sh 0x3F` gives `rspErr=1`;
  - `reqSize=11` gives `rspErr=1`;
  - memory is unchanged afterwards.
- Throughput: 4 back-to-back aligned `lw`. `reqReady` stays high and `rspValid` is high for 4 consecutive cycles with the correct data.
- Reset abort: assert `rst` in the `SPLIT` cycle of a load. Outputs drop to 0 immediately, no response is produced, and `CLEAR` restarts at index 0.
